// File: rtl/alu_cmp_pkg.sv
// Shared types and flag-selection helper for the iterative compare unit.
package alu_cmp_pkg;

    typedef enum logic [1:0] {
        CMP_SLTU = 2'b00,
        CMP_SLT  = 2'b01,
        CMP_SEQ  = 2'b10,
        CMP_SNE  = 2'b11
    } cmp_mode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_BUSY = 2'b01,
        S_DONE = 2'b10
    } cmp_state_e;

    // Final carry of a - b (carry set means no borrow, i.e. a >= b unsigned).
    // For signed compare, differing sign bits decide directly: the negative
    // operand (msb set) is the smaller one.
    function automatic logic cmp_flag(input cmp_mode_e mode,
                                      input logic      carry,
                                      input logic      eq,
                                      input logic      a_msb,
                                      input logic      b_msb);
        logic ltu;
        ltu = ~carry;
        case (mode)
            CMP_SLTU: cmp_flag = ltu;
            CMP_SLT:  cmp_flag = (a_msb != b_msb) ? a_msb : ltu;
            CMP_SEQ:  cmp_flag = eq;
            default:  cmp_flag = ~eq;
        endcase
    endfunction

endpackage

// File: rtl/alu_cmp_chunk.sv
// One CHUNK-bit slice of the a - b subtract: full-adder carry chain over
// a + ~b + carry_i, plus an equality flag for the slice. Only the carry out
// is needed by the compare, so the sum bits are not produced.
module alu_cmp_chunk #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             carry_i,
    output logic             carry_o,
    output logic             eq_o
);

    logic [CHUNK:0]   c;
    logic [CHUNK-1:0] b_inv;

    assign b_inv = ~b_i;
    assign c[0]  = carry_i;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        assign c[i+1] = (a_i[i] & b_inv[i]) | (c[i] & (a_i[i] ^ b_inv[i]));
    end

    assign carry_o = c[CHUNK];
    assign eq_o    = (a_i == b_i);

endmodule

// File: rtl/alu_cmp_iter.sv
// Multi-cycle compare unit: SLTU/SLT/SEQ/SNE over WIDTH-bit operands,
// processed CHUNK bits per cycle LSB first with a ripple-borrow subtract.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | ready for a request; operands latched on i_valid
// S_BUSY | one chunk per cycle, NCYC cycles, carry/eq accumulate
// S_DONE | flag registered, o_valid high until i_ready
module alu_cmp_iter
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result
);

    localparam int NCYC  = WIDTH / CHUNK;
    localparam int CNT_W = $clog2(NCYC) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCYC - 1);

    if ((WIDTH < 2) || (CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_param
        $error("alu_cmp_iter: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    cmp_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    cmp_mode_e        mode_q, mode_d;
    logic             carry_q, carry_d;
    logic             eq_q, eq_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             flag_q, flag_d;

    logic             carry_nxt;
    logic             eq_chunk;
    logic             eq_acc;

    alu_cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
        .a_i     (a_q[CHUNK-1:0]),
        .b_i     (b_q[CHUNK-1:0]),
        .carry_i (carry_q),
        .carry_o (carry_nxt),
        .eq_o    (eq_chunk)
    );

    assign eq_acc   = eq_q & eq_chunk;
    assign o_result = {{(WIDTH-1){1'b0}}, flag_q};

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        cnt_d   = cnt_q;
        a_msb_d = a_msb_q;
        b_msb_d = b_msb_q;
        flag_d  = flag_q;
        o_ready = 1'b0;
        o_valid = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    a_d     = i_a;
                    b_d     = i_b;
                    mode_d  = cmp_mode_e'(i_mode);
                    carry_d = 1'b1;
                    eq_d    = 1'b1;
                    cnt_d   = '0;
                    a_msb_d = i_a[WIDTH-1];
                    b_msb_d = i_b[WIDTH-1];
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                carry_d = carry_nxt;
                eq_d    = eq_acc;
                a_d     = a_q >> CHUNK;
                b_d     = b_q >> CHUNK;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    flag_d  = cmp_flag(mode_q, carry_nxt, eq_acc, a_msb_q, b_msb_q);
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any in-flight request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= CMP_SLTU;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
            cnt_q   <= cnt_d;
            a_msb_q <= a_msb_d;
            b_msb_q <= b_msb_d;
            flag_q  <= flag_d;
        end
    end

endmodule
